acc_adder_tree: RTL and testbench
=================================

Name: acc_adder_tree

Overview:
- Parametrised, pipelined signed adder tree with a post-tree channel accumulator.
- Sums NUM_IN signed IN_W-bit products per beat.
- Accumulates successive beats, one per input channel, between first/last markers.
- Emits one OUT_W-bit result per accumulation group. Sits between the MAC array and the output buffer of the convolution engine.

Parameters:
- NUM_IN, 9, number of operands summed per beat (>=2).
- IN_W, 15, signed operand width.
- OUT_W, 32, signed accumulator/output width (>= IN_W + clog2(NUM_IN)).
- STAGES, derived = clog2(NUM_IN), tree depth; localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand vector valid this cycle.
- in_first  in  1  beat is first of an accumulation group; qualified by in_valid.
- in_last  in  1  beat is last of an accumulation group; qualified by in_valid.
- in_data  in  NUM_IN*IN_W  packed signed operands, operand k at [k*IN_W +: IN_W].
- out_valid  out  1  accumulated result valid, one-cycle pulse.
- out_data  out  OUT_W  signed accumulated result.
- busy  out  1  any valid beat in tree or group open in accumulator.

Behaviour:
- Reset: all pipeline registers, valid/flag shift chains, accumulator and group-open flag clear to 0. out_valid=0, out_data=0, busy=0.
- Reset is asynchronous. Asserting it mid-group discards the partial sum; no output is produced for that group.
- Sign extension: each operand is sign-extended to OUT_W before stage 1. All adds are OUT_W two's complement and wrap modulo 2^OUT_W; no saturation (except the optional feature).
- Tree: stage s pairs adjacent values from stage s-1.
  - An odd leftover value is passed through a register unchanged, so every path has equal depth.
  - Every stage is registered.
  - Tree output is valid STAGES cycles after in_valid.
- in_valid, in_first and in_last travel in a STAGES-deep shift register alongside the data.
- No backpressure: one beat per cycle is accepted unconditionally. Beats with in_valid=0 create bubbles and are ignored by the accumulator.
- Accumulator stage, one registered cycle, acting on the tree-output valid t_v with flags t_f/t_l and sum S:
  - t_v=0: hold acc; out_valid=0.
  - t_v=1, t_f=1, t_l=0: acc<=S; group open.
  - t_v=1, t_f=0, t_l=0: acc<=acc+S.
  - t_v=1, t_l=1: out_data<=(t_f ? S : acc+S); out_valid<=1; acc<=0; group closed.
  - t_v=1, t_f=0 with no group open: accumulate onto acc=0, i.e. treated as an implicit first.
  - t_f=1 while a group is open: the previous partial is discarded and a new group starts.
- Total latency from in_valid of a last beat to out_valid: STAGES+1 cycles. For NUM_IN=9 this is 5.
- out_data holds its value between pulses. out_valid is high for exactly one cycle per closed group.
- Back-to-back groups (last immediately followed by first) sustain full throughput with no bubble.
- busy = OR of the valid chain OR group-open flag.

Optional Feature:
- Macro: ACC_ADDER_TREE_RELU_EN.
- Defined: when a result is produced, out_data is replaced with 0 if the final sum is negative (MSB=1). Accumulator internals are unaffected. Latency is unchanged.
- Undefined: out_data is the raw signed sum.

Decomposition:
- Shared package: clog2 function, default IN_W/OUT_W/NUM_IN constants, packed operand-vector typedef.
- One natural sub-module: acc_tree_stage. It is one registered reduction level, parametrised by input count and width, with pass-through of the odd element and valid/flag forwarding. The top instantiates STAGES copies via a generate loop, plus the accumulator.

Test Plan:
- Single beat, first=last=1, operands 1..9 -> out_valid after 5 cycles, out_data=45.
- Sign extension: all nine operands = -16384 (15'h4000), first=last=1 -> out_data=-147456.
- Three-beat group: operands all 1, then all 2, then all -1 (first on beat 1, last on beat 3) -> one pulse, out_data=18, 5 cycles after beat 3.
- Streaming with bubbles: groups of 2 beats back-to-back, in_valid toggled 1,0,1,1,1 -> pulses on correct cycles, no lost or duplicated beats; busy deasserts 5 cycles after the final beat.
- Reset mid-group: rst_n low for 1 cycle after first beat -> no out_valid, next group result uncontaminated.
- With ACC_ADDER_TREE_RELU_EN: single beat, all operands -1 -> out_data=0. Without the macro, the same stimulus gives out_data=-9.

Source files
------------

// File: rtl/acc_adder_tree_pkg.sv
// Shared definitions for the accumulating adder tree: default sizes,
// operand-vector type and elaboration-time helpers that size the tree levels.
package acc_adder_tree_pkg;

   localparam int DEF_NUM_IN = 9;
   localparam int DEF_IN_W   = 15;
   localparam int DEF_OUT_W  = 32;

   // One beat of operands as delivered by the MAC array.
   typedef logic [DEF_NUM_IN-1:0][DEF_IN_W-1:0] opvec_t;

   // Ceiling log2; the tree depth for n operands.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Number of values present at tree level s (level 0 = the raw operands).
   function automatic int tree_cnt(input int n, input int s);
      int c;
      c = n;
      for (int i = 0; i < s; i++) c = (c + 1) / 2;
      return c;
   endfunction

   // Offset (in values) of level s inside the flattened level vector.
   function automatic int tree_off(input int n, input int s);
      int o;
      o = 0;
      for (int i = 0; i < s; i++) o += tree_cnt(n, i);
      return o;
   endfunction

endpackage

// File: rtl/acc_adder_tree_stage.sv
// One registered reduction level of the adder tree. Adjacent pairs are
// summed; an odd trailing value is registered unchanged so all paths through
// the tree have equal depth. Beat qualifiers ride along in lock-step.
module acc_tree_stage #(
   parameter int N_IN = 2,
   parameter int W    = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            valid_i,
   input  logic                            first_i,
   input  logic                            last_i,
   input  logic [N_IN-1:0][W-1:0]          data_i,
   output logic                            valid_o,
   output logic                            first_o,
   output logic                            last_o,
   output logic [(N_IN+1)/2-1:0][W-1:0]    data_o
);

   localparam int N_OUT = (N_IN + 1) / 2;

   logic [N_OUT-1:0][W-1:0] data_d, data_q;
   logic                    valid_q, first_q, last_q;

   // Pairwise sums; adds wrap modulo 2^W, which is two's-complement correct.
   for (genvar j = 0; j < N_OUT; j++) begin : g_pair
      if (2 * j + 1 < N_IN) begin : g_add
         assign data_d[j] = data_i[2*j] + data_i[2*j+1];
      end else begin : g_pass
         assign data_d[j] = data_i[2*j];
      end
   end

   // Register the reduced level and forward the beat qualifiers alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_i;
         first_q <= first_i;
         last_q  <= last_i;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign first_o = first_q;
   assign last_o  = last_q;

endmodule

// File: rtl/acc_adder_tree.sv
// Pipelined signed adder tree followed by a per-group channel accumulator.
// Each beat sums NUM_IN sign-extended operands through clog2(NUM_IN)
// registered levels; the accumulator folds beats between first/last markers
// and emits one result pulse per group.
// Optional build macro ACC_ADDER_TREE_RELU_EN: clamp negative results to 0
// on the output only (accumulator state is unaffected).
module acc_adder_tree
   import acc_adder_tree_pkg::*;
#(
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int IN_W   = DEF_IN_W,
   parameter int OUT_W  = DEF_OUT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic                   in_first,
   input  logic                   in_last,
   input  logic [NUM_IN*IN_W-1:0] in_data,
   output logic                   out_valid,
   output logic [OUT_W-1:0]       out_data,
   output logic                   busy
);

   localparam int STAGES = clog2(NUM_IN);
   // Total values across all levels, level 0 (operands) through the root.
   localparam int TOT    = tree_off(NUM_IN, STAGES + 1);

   // All tree levels packed back to back; level s starts at tree_off(s).
   logic [TOT*OUT_W-1:0] lvl;
   logic [STAGES:0]      vld_pipe, fst_pipe, lst_pipe;

   assign vld_pipe[0] = in_valid;
   assign fst_pipe[0] = in_first;
   assign lst_pipe[0] = in_last;

   // Level 0: operands sign-extended to the accumulator width.
   for (genvar k = 0; k < NUM_IN; k++) begin : g_sext
      assign lvl[k*OUT_W +: OUT_W] =
         {{(OUT_W-IN_W){in_data[k*IN_W+IN_W-1]}}, in_data[k*IN_W +: IN_W]};
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int NI    = tree_cnt(NUM_IN, s);
      localparam int NO    = tree_cnt(NUM_IN, s + 1);
      localparam int OFF_I = tree_off(NUM_IN, s);
      localparam int OFF_O = tree_off(NUM_IN, s + 1);

      acc_tree_stage #(
         .N_IN (NI),
         .W    (OUT_W)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .valid_i (vld_pipe[s]),
         .first_i (fst_pipe[s]),
         .last_i  (lst_pipe[s]),
         .data_i  (lvl[OFF_I*OUT_W +: NI*OUT_W]),
         .valid_o (vld_pipe[s+1]),
         .first_o (fst_pipe[s+1]),
         .last_o  (lst_pipe[s+1]),
         .data_o  (lvl[OFF_O*OUT_W +: NO*OUT_W])
      );
   end

   // Tree root and its qualifiers.
   logic             t_v, t_f, t_l;
   logic [OUT_W-1:0] t_sum;

   assign t_v   = vld_pipe[STAGES];
   assign t_f   = fst_pipe[STAGES];
   assign t_l   = lst_pipe[STAGES];
   assign t_sum = lvl[(TOT-1)*OUT_W +: OUT_W];

   logic [OUT_W-1:0] acc_d, acc_q;
   logic [OUT_W-1:0] out_data_d, out_data_q;
   logic             out_valid_d, out_valid_q;
   logic             open_d, open_q;
   logic [OUT_W-1:0] base, sum;

   // Accumulator next state: a first marker (or a beat with no open group)
   // restarts from zero, a last marker closes the group and emits the total.
   always_comb begin
      acc_d       = acc_q;
      open_d      = open_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      base        = (t_f || !open_q) ? '0 : acc_q;
      sum         = base + t_sum;
      if (t_v) begin
         if (t_l) begin
            out_valid_d = 1'b1;
`ifdef ACC_ADDER_TREE_RELU_EN
            out_data_d  = sum[OUT_W-1] ? '0 : sum;
`else
            out_data_d  = sum;
`endif
            acc_d       = '0;
            open_d      = 1'b0;
         end else begin
            acc_d       = sum;
            open_d      = 1'b1;
         end
      end
   end

   // Accumulator and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         open_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         acc_q       <= acc_d;
         open_q      <= open_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   // Busy while any beat is inside the tree or a group is still open.
   assign busy      = (|vld_pipe[STAGES:1]) | open_q;

endmodule

// File: tb/tb_acc_adder_tree.sv
// Bench for acc_adder_tree: directed cases with hand-computed results, then
// random streaming checked every cycle against a group-level model.
module tb_acc_adder_tree;

   localparam int NUM_IN = 9;
   localparam int IN_W   = 15;
   localparam int OUT_W  = 32;
   localparam int STAGES = $clog2(NUM_IN);
   localparam int HMAX   = 8192;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
   logic [NUM_IN*IN_W-1:0] in_data = '0;
   logic                   out_valid;
   logic [OUT_W-1:0]       out_data;
   logic                   busy;

   int n_chk = 0;
   int n_err = 0;
   int edge_n = 0;
   bit chk_en = 1'b0;

   // Model state: expected pulses keyed by the edge after which they appear,
   // plus per-edge history of sampled valid beats and group-open state.
   bit exp_ov[HMAX];
   int exp_od[HMAX];
   bit vhist[HMAX];
   bit open_hist[HMAX];
   bit m_open = 1'b0;
   int m_acc = 0;
   int last_od = 0;
   int last_res = 0;

   acc_adder_tree #(
      .NUM_IN (NUM_IN),
      .IN_W   (IN_W),
      .OUT_W  (OUT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .in_last   (in_last),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic int relu(int v);
`ifdef ACC_ADDER_TREE_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic chk(string nm, logic signed [31:0] act, logic signed [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
      end
   endtask

   // Present one beat and advance the group model for the edge that samples it.
   task automatic drive(bit v, bit f, bit l, int ops[NUM_IN]);
      int s;
      int k;
      @(posedge clk);
      #2;
      in_valid = v;
      in_first = f;
      in_last  = l;
      for (int i = 0; i < NUM_IN; i++) in_data[i*IN_W +: IN_W] = ops[i][IN_W-1:0];
      k = edge_n + 1;
      if (v) begin
         s = 0;
         for (int i = 0; i < NUM_IN; i++) s += ops[i];
         if (f || !m_open) m_acc = s;
         else              m_acc += s;
         m_open = 1'b1;
         if (l) begin
            last_res = relu(m_acc);
            exp_ov[k+STAGES] = 1'b1;
            exp_od[k+STAGES] = last_res;
            m_open = 1'b0;
            m_acc  = 0;
         end
      end
      vhist[k]     = v;
      open_hist[k] = m_open;
   endtask

   task automatic idle();
      int z[NUM_IN];
      for (int i = 0; i < NUM_IN; i++) z[i] = 0;
      drive(1'b0, 1'b0, 1'b0, z);
   endtask

   task automatic fill(output int ops[NUM_IN], input int v);
      for (int i = 0; i < NUM_IN; i++) ops[i] = v;
   endtask

   // One-cycle asynchronous reset pulse; everything in flight is forgotten.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      m_open   = 1'b0;
      m_acc    = 0;
      last_od  = 0;
      for (int i = 0; i < HMAX; i++) begin
         exp_ov[i]    = 1'b0;
         exp_od[i]    = 0;
         vhist[i]     = 1'b0;
         open_hist[i] = 1'b0;
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // After a last beat: wait for the pulse, check its latency and value, and
   // check that the model agrees with the hand-computed value.
   task automatic wait_result(string nm, int exp_val);
      int p;
      int lat;
      p   = edge_n;
      lat = -1;
      chk({nm, "_model"}, last_res, exp_val);
      for (int i = 0; i < 20; i++) begin
         idle();
         @(negedge clk);
         if (out_valid) begin
            lat = edge_n - p;
            chk({nm, "_data"}, out_data, exp_val);
            break;
         end
      end
      chk({nm, "_latency"}, lat, 5);
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin : cmp
      int  n;
      bit  eb;
      if (chk_en) begin
         n = edge_n;
         if (!rst_n) begin
            chk("rst_out_valid", {31'b0, out_valid}, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_busy", {31'b0, busy}, 0);
         end else begin
            if (exp_ov[n]) last_od = exp_od[n];
            eb = (n >= STAGES) ? open_hist[n-STAGES] : 1'b0;
            for (int i = 0; i < STAGES; i++) if (n - i >= 0 && vhist[n-i]) eb = 1'b1;
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov[n]});
            chk("out_data", out_data, last_od);
            chk("busy", {31'b0, busy}, {31'b0, eb});
         end
      end
   end

   initial begin
      int ops[NUM_IN];
      int p;
      int lat;
      bit v, f, l;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", {31'b0, out_valid}, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_busy", {31'b0, busy}, 0);
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Single beat, operands 1..9.
      for (int i = 0; i < NUM_IN; i++) ops[i] = i + 1;
      drive(1'b1, 1'b1, 1'b1, ops);
      wait_result("single", 45);

      // Sign extension: all operands at the most negative value.
      fill(ops, -16384);
      drive(1'b1, 1'b1, 1'b1, ops);
      wait_result("sext", `ifdef ACC_ADDER_TREE_RELU_EN 0 `else -147456 `endif);

      // Three-beat group.
      fill(ops, 1);  drive(1'b1, 1'b1, 1'b0, ops);
      fill(ops, 2);  drive(1'b1, 1'b0, 1'b0, ops);
      fill(ops, -1); drive(1'b1, 1'b0, 1'b1, ops);
      wait_result("three_beat", 18);

      // ReLU case: all -1.
      fill(ops, -1);
      drive(1'b1, 1'b1, 1'b1, ops);
      wait_result("all_neg", `ifdef ACC_ADDER_TREE_RELU_EN 0 `else -9 `endif);

      // Streaming with a bubble: two 2-beat groups back to back.
      fill(ops, 3);  drive(1'b1, 1'b1, 1'b0, ops);
      fill(ops, 99); drive(1'b0, 1'b1, 1'b1, ops);
      fill(ops, 4);  drive(1'b1, 1'b0, 1'b1, ops);
      chk("stream_g1_model", last_res, 63);
      fill(ops, -2); drive(1'b1, 1'b1, 1'b0, ops);
      fill(ops, 5);  drive(1'b1, 1'b0, 1'b1, ops);
      chk("stream_g2_model", last_res, 27);
      p   = edge_n;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         idle();
         @(negedge clk);
         if (!busy) begin
            lat = edge_n - p;
            break;
         end
      end
      chk("busy_drop", lat, 5);

      // Reset mid-group: partial sum must not leak into the next group.
      fill(ops, 7);
      drive(1'b1, 1'b1, 1'b0, ops);
      do_reset();
      fill(ops, 1);
      drive(1'b1, 1'b1, 1'b1, ops);
      wait_result("after_reset", 9);

      // Random streaming, including qualifier noise on bubbles and a reset.
      for (int it = 0; it < 2000; it++) begin
         v = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 3) == 0);
         l = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 9))
            0:       fill(ops, -16384);
            1:       fill(ops, 16383);
            default: for (int i = 0; i < NUM_IN; i++) ops[i] = int'($urandom_range(0, 32767)) - 16384;
         endcase
         drive(v, f, l, ops);
         if (it == 1000) do_reset();
      end
      repeat (10) idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
